// File: rtl/branch_resolve_unit.sv
// Two-stage branch/jump resolution unit: E1 captures operands, E2 registers the resolved result.
// Define BRU_STATS_EN to add the branch and mispredict handshake counters.
module branch_resolve_unit #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int IMM_WIDTH     = 13,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int PREG_WIDTH    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_pc,
  input  logic [DATA_WIDTH-1:0]    in_rs1,
  input  logic [DATA_WIDTH-1:0]    in_rs2,
  input  logic [IMM_WIDTH-1:0]     in_imm,
  input  logic [6:0]               in_opcode,
  input  logic [2:0]               in_funct3,
  input  logic                     in_pred_taken,
  input  logic [ADDR_WIDTH-1:0]    in_pred_target,
  input  logic [ROB_IDX_WIDTH-1:0] in_rob_idx,
  input  logic [PREG_WIDTH-1:0]    in_prd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROB_IDX_WIDTH-1:0] out_rob_idx,
  output logic [PREG_WIDTH-1:0]    out_prd,
  output logic                     out_link_we,
  output logic [DATA_WIDTH-1:0]    out_link_data,
  output logic                     out_taken,
  output logic                     out_mispredict,
  output logic                     redirect_valid,
  output logic [ADDR_WIDTH-1:0]    redirect_pc,
  input  logic                     flush
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispredicts
`endif
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic                     e1_valid;
  logic [ADDR_WIDTH-1:0]    e1_pc;
  logic [DATA_WIDTH-1:0]    e1_rs1;
  logic [DATA_WIDTH-1:0]    e1_rs2;
  logic [ADDR_WIDTH-1:0]    e1_imm;
  logic [6:0]               e1_opcode;
  logic [2:0]               e1_funct3;
  logic                     e1_pred_taken;
  logic [ADDR_WIDTH-1:0]    e1_pred_target;
  logic [ROB_IDX_WIDTH-1:0] e1_rob_idx;
  logic [PREG_WIDTH-1:0]    e1_prd;

  logic [ADDR_WIDTH-1:0]    e2_cpc;

  logic                     is_br;
  logic                     is_jal;
  logic                     is_jalr;
  logic                     cond;
  logic                     taken;
  logic                     mispredict;
  logic [ADDR_WIDTH-1:0]    pc_plus4;
  logic [ADDR_WIDTH-1:0]    jalr_sum;
  logic [ADDR_WIDTH-1:0]    target;
  logic [ADDR_WIDTH-1:0]    cpc;
  logic                     handshake;
  logic                     e2_adv;

  assign handshake = out_valid && out_ready;
  assign e2_adv    = !out_valid || out_ready;
  assign in_ready  = !flush && (!e1_valid || e2_adv);

  always_comb begin
    is_br      = (e1_opcode == OP_BRANCH);
    is_jal     = (e1_opcode == OP_JAL);
    is_jalr    = (e1_opcode == OP_JALR);
    cond       = 1'b0;
    case (e1_funct3)
      3'b000:  cond = (e1_rs1 == e1_rs2);
      3'b001:  cond = (e1_rs1 != e1_rs2);
      3'b100:  cond = ($signed(e1_rs1) <  $signed(e1_rs2));
      3'b101:  cond = ($signed(e1_rs1) >= $signed(e1_rs2));
      3'b110:  cond = (e1_rs1 <  e1_rs2);
      3'b111:  cond = (e1_rs1 >= e1_rs2);
      default: cond = 1'b0;
    endcase
    pc_plus4   = e1_pc + ADDR_WIDTH'(4);
    jalr_sum   = ADDR_WIDTH'(e1_rs1) + e1_imm;
    target     = is_jalr ? {jalr_sum[ADDR_WIDTH-1:1], 1'b0} : (e1_pc + e1_imm);
    taken      = is_br ? cond : (is_jal || is_jalr);
    // Unrecognised opcodes never mispredict, whatever the front end guessed.
    mispredict = (is_br || is_jal || is_jalr) &&
                 ((taken != e1_pred_taken) || (taken && (target != e1_pred_target)));
    cpc        = taken ? target : pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_valid       <= 1'b0;
      e1_pc          <= '0;
      e1_rs1         <= '0;
      e1_rs2         <= '0;
      e1_imm         <= '0;
      e1_opcode      <= '0;
      e1_funct3      <= '0;
      e1_pred_taken  <= 1'b0;
      e1_pred_target <= '0;
      e1_rob_idx     <= '0;
      e1_prd         <= '0;
    end else if (flush) begin
      e1_valid <= 1'b0;
    end else if (in_ready) begin
      e1_valid <= in_valid;
      if (in_valid) begin
        e1_pc          <= in_pc;
        e1_rs1         <= in_rs1;
        e1_rs2         <= in_rs2;
        e1_imm         <= {{(ADDR_WIDTH-IMM_WIDTH){in_imm[IMM_WIDTH-1]}}, in_imm};
        e1_opcode      <= in_opcode;
        e1_funct3      <= in_funct3;
        e1_pred_taken  <= in_pred_taken;
        e1_pred_target <= in_pred_target;
        e1_rob_idx     <= in_rob_idx;
        e1_prd         <= in_prd;
      end
    end
  end

  // E2 only reloads when empty or draining, so a stalled result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_rob_idx    <= '0;
      out_prd        <= '0;
      out_link_we    <= 1'b0;
      out_link_data  <= '0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      e2_cpc         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= handshake && out_mispredict;
      if (handshake && out_mispredict)
        redirect_pc <= e2_cpc;
      if (e2_adv) begin
        out_valid <= e1_valid;
        if (e1_valid) begin
          out_rob_idx    <= e1_rob_idx;
          out_prd        <= e1_prd;
          out_link_we    <= is_jal || is_jalr;
          out_link_data  <= DATA_WIDTH'(pc_plus4);
          out_taken      <= taken;
          out_mispredict <= mispredict;
          e2_cpc         <= cpc;
        end
      end
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (handshake && !flush) begin
      stat_branches <= stat_branches + 32'd1;
      if (out_mispredict)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a driver pushes model results on accept,
// a negedge monitor pops and compares on every output handshake and checks redirect pulses.
module tb_branch_resolve_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [12:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [4:0]  rob;
    logic [5:0]  prd;
  } op_t;

  typedef struct {
    logic [4:0]  rob;
    logic [5:0]  prd;
    logic        link_we;
    logic [31:0] link_data;
    logic        taken;
    logic        mis;
    logic [31:0] cpc;
    logic [31:0] target;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [12:0] in_imm = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_pred_taken = 1'b0;
  logic [31:0] in_pred_target = '0;
  logic [4:0]  in_rob_idx = '0;
  logic [5:0]  in_prd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_rob_idx;
  logic [5:0]  out_prd;
  logic        out_link_we;
  logic [31:0] out_link_data;
  logic        out_taken;
  logic        out_mispredict;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush = 1'b0;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
  int          mdl_br = 0;
  int          mdl_mis = 0;
`endif

  int   n_checks = 0;
  int   n_fails = 0;
  exp_t exp_q[$];
  op_t  idle = '{default: '0};

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .in_rob_idx(in_rob_idx), .in_prd(in_prd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rob_idx(out_rob_idx), .out_prd(out_prd),
    .out_link_we(out_link_we), .out_link_data(out_link_data),
    .out_taken(out_taken), .out_mispredict(out_mispredict),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush)
`ifdef BRU_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Reference behaviour straight from the ISA rules.
  function automatic exp_t model(op_t o);
    exp_t        e;
    logic [31:0] imm;
    logic        ctrl;
    imm  = {{19{o.imm[12]}}, o.imm};
    ctrl = 1'b1;
    e.taken  = 1'b0;
    e.target = o.pc + imm;
    case (o.opcode)
      7'b1100011: begin
        case (o.funct3)
          3'd0: e.taken = (o.rs1 == o.rs2);
          3'd1: e.taken = (o.rs1 != o.rs2);
          3'd4: e.taken = ($signed(o.rs1) < $signed(o.rs2));
          3'd5: e.taken = !($signed(o.rs1) < $signed(o.rs2));
          3'd6: e.taken = (o.rs1 < o.rs2);
          3'd7: e.taken = !(o.rs1 < o.rs2);
          default: e.taken = 1'b0;
        endcase
      end
      7'b1101111: e.taken = 1'b1;
      7'b1100111: begin
        e.taken  = 1'b1;
        e.target = (o.rs1 + imm) & 32'hFFFF_FFFE;
      end
      default: ctrl = 1'b0;
    endcase
    e.rob       = o.rob;
    e.prd       = o.prd;
    e.link_we   = ctrl && (o.opcode != 7'b1100011);
    e.link_data = o.pc + 32'd4;
    e.mis       = ctrl && ((e.taken != o.pred_taken) || (e.taken && e.target != o.pred_target));
    e.cpc       = e.taken ? e.target : o.pc + 32'd4;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs just after the edge; record acceptance at the negedge.
  task automatic applyStimulus(input op_t o, input bit v, input bit ordy, input bit fl, output bit acc);
    @(posedge clk);
    #1;
    in_valid = v; out_ready = ordy; flush = fl;
    in_pc = o.pc; in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm;
    in_opcode = o.opcode; in_funct3 = o.funct3;
    in_pred_taken = o.pred_taken; in_pred_target = o.pred_target;
    in_rob_idx = o.rob; in_prd = o.prd;
    @(negedge clk);
    acc = v && in_ready;
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(model(o));
  endtask

  task automatic issueAndTime(input op_t o);
    bit acc;
    applyStimulus(o, 1, 1, 0, acc);
    checkOutput("accept", 32'(acc), 32'd1);
    applyStimulus(idle, 0, 1, 0, acc);
    checkOutput("latency_cycle1_valid", 32'(out_valid), 32'd0);
    applyStimulus(idle, 0, 1, 0, acc);
    checkOutput("latency_cycle2_valid", 32'(out_valid), 32'd1);
    applyStimulus(idle, 0, 1, 0, acc);
    applyStimulus(idle, 0, 1, 0, acc);
  endtask

  function automatic op_t mkop(logic [6:0] opc, logic [2:0] f3, logic [31:0] pc, logic [31:0] rs1,
                               logic [31:0] rs2, logic [12:0] imm, logic pt, logic [31:0] ptgt, logic [4:0] rob);
    op_t o;
    o.opcode = opc; o.funct3 = f3; o.pc = pc; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm;
    o.pred_taken = pt; o.pred_target = ptgt; o.rob = rob; o.prd = {1'b1, rob};
    return o;
  endfunction

  // Monitor: redirect pulse must follow exactly the mispredicted handshakes.
  logic        pend = 1'b0;
  logic [31:0] pend_pc = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pend = 1'b0;
`ifdef BRU_STATS_EN
      mdl_br = 0; mdl_mis = 0;
`endif
    end else begin
      checkOutput("redirect_valid", 32'(redirect_valid), 32'(pend));
      if (pend) checkOutput("redirect_pc", redirect_pc, pend_pc);
      pend = 1'b0;
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fails++;
          $display("[TB] FAIL unexpected_output actual=rob%0h required=none", out_rob_idx);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rob_idx", 32'(out_rob_idx), 32'(e.rob));
          checkOutput("prd", 32'(out_prd), 32'(e.prd));
          checkOutput("link_we", 32'(out_link_we), 32'(e.link_we));
          if (e.link_we) checkOutput("link_data", out_link_data, e.link_data);
          checkOutput("taken", 32'(out_taken), 32'(e.taken));
          checkOutput("mispredict", 32'(out_mispredict), 32'(e.mis));
          pend = e.mis; pend_pc = e.cpc;
`ifdef BRU_STATS_EN
          mdl_br++; if (e.mis) mdl_mis++;
`endif
        end
      end
    end
  end

  initial begin
    bit  acc;
    int  naccept;
    op_t o;
    exp_t e;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_redirect_valid", 32'(redirect_valid), 32'd0);
    #2 rst_n = 1'b1;
    applyStimulus(idle, 0, 1, 0, acc);
    checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

    $display("[TB] directed BEQ / BLT / JALR");
    issueAndTime(mkop(7'b1100011, 3'b000, 32'h100, 32'd5, 32'd5, 13'h020, 1'b1, 32'h120, 5'd1));
    issueAndTime(mkop(7'b1100011, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 13'h1FF8, 1'b0, 32'h0, 5'd2));
    issueAndTime(mkop(7'b1100111, 3'b000, 32'h40, 32'h1003, 32'd0, 13'h002, 1'b1, 32'h1004, 5'd3));

    $display("[TB] stall with continuous issue");
    naccept = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mkop(7'b1101111, 3'b000, 32'h300 + 32'(i * 4), 32'd0, 32'd0, 13'h010, 1'b1, 32'h0,
                         5'(4 + i)), 1, 0, 0, acc);
      if (acc) naccept++;
    end
    checkOutput("stall_accepts", 32'(naccept), 32'd2);
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    repeat (4) applyStimulus(idle, 0, 1, 0, acc);
    checkOutput("stall_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] flush with both stages full");
    applyStimulus(mkop(7'b1100011, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 13'h1FF8, 1'b0, 32'h0, 5'd10), 1, 0, 0, acc);
    applyStimulus(mkop(7'b1100011, 3'b100, 32'h204, 32'hFFFF_FFFF, 32'd1, 13'h1FF8, 1'b0, 32'h0, 5'd11), 1, 0, 0, acc);
    applyStimulus(idle, 1, 1, 1, acc);
    checkOutput("flush_blocks_accept", 32'(acc), 32'd0);
    applyStimulus(idle, 0, 1, 0, acc);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(idle, 0, 1, 0, acc);

    $display("[TB] reset mid-stall");
    applyStimulus(mkop(7'b1101111, 3'b000, 32'h500, 32'd0, 32'd0, 13'h040, 1'b0, 32'h0, 5'd20), 1, 0, 0, acc);
    applyStimulus(mkop(7'b1101111, 3'b000, 32'h504, 32'd0, 32'd0, 13'h040, 1'b0, 32'h0, 5'd21), 1, 0, 0, acc);
    applyStimulus(idle, 0, 0, 0, acc);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("rst_link_we", 32'(out_link_we), 32'd0);
    checkOutput("rst_taken", 32'(out_taken), 32'd0);
    checkOutput("rst_mispredict", 32'(out_mispredict), 32'd0);
    checkOutput("rst_rob_idx", 32'(out_rob_idx), 32'd0);
    checkOutput("rst_prd", 32'(out_prd), 32'd0);
    checkOutput("rst_link_data", out_link_data, 32'd0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
`ifdef BRU_STATS_EN
    checkOutput("rst_stat_branches", stat_branches, 32'd0);
    checkOutput("rst_stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(idle, 0, 1, 0, acc);
    checkOutput("in_ready_after_midreset", 32'(in_ready), 32'd1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: o.opcode = 7'b1100011;
        6:                o.opcode = 7'b1101111;
        7:                o.opcode = 7'b1100111;
        default:          o.opcode = 7'b0110011;
      endcase
      o.funct3      = 3'($urandom_range(0, 7));
      o.pc          = $urandom;
      o.rs1         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      o.rs2         = ($urandom_range(0, 3) == 0) ? o.rs1 : $urandom;
      o.imm         = 13'($urandom);
      o.pred_taken  = 1'($urandom);
      o.pred_target = $urandom;
      o.rob         = 5'(i);
      o.prd         = 6'($urandom);
      e = model(o);
      if ($urandom_range(0, 1) == 1) o.pred_target = e.target;
      applyStimulus(o, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, acc);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) applyStimulus(idle, 0, 1, 0, acc);
    checkOutput("final_drain", 32'(exp_q.size()), 32'd0);
    applyStimulus(idle, 0, 1, 0, acc);
`ifdef BRU_STATS_EN
    checkOutput("stat_branches", stat_branches, 32'(mdl_br));
    checkOutput("stat_mispredicts", stat_mispredicts, 32'(mdl_mis));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
